// File: rtl/snn_input_loader_if.sv
// Bundle of the UART-side, core-side and status signals of snn_input_loader.
// The slave modport is the loader; the master modport is the UART receiver / SNN core side.
interface snn_input_loader_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;
  logic [9:0] addr_input_unit;
  logic       q_input;
  logic       core_done;
  logic       start;
  logic       busy;
  logic       frame_err;

  modport slave (
    input  rx_rdy, rx_data, addr_input_unit, core_done,
    output clr_rx_rdy, q_input, start, busy, frame_err
  );

  modport master (
    output rx_rdy, rx_data, addr_input_unit, core_done,
    input  clr_rx_rdy, q_input, start, busy, frame_err
  );
endinterface

// File: rtl/snn_input_loader.sv
// Unpacks 98 UART bytes LSB-first into a 784 x 1-bit image memory, starts the SNN core and
// serves its reads. Optional inter-byte timeout: define SNN_INPUT_LOADER_TIMEOUT_EN.
module snn_input_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic               clk,
  input logic               rst_n,
  snn_input_loader_if.slave ldr
);

  localparam logic [1:0] StLoad     = 2'd0;
  localparam logic [1:0] StUnpack   = 2'd1;
  localparam logic [1:0] StStart    = 2'd2;
  localparam logic [1:0] StWaitCore = 2'd3;

  localparam int unsigned MemDepth = 784;
  localparam logic [6:0]  LastByte = 7'd97;

  logic [1:0] state_q, state_d;
  logic [6:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       q_input_q, q_input_d;
  logic       clr_rx_rdy;
  logic       mem_we;
  logic       timeout;
  logic [9:0] waddr;
  logic       mem_q [MemDepth];

`ifdef SNN_INPUT_LOADER_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IdleW-1:0] idle_q, idle_d;
  logic             frame_err_q, frame_err_d;

  // Idle time only accrues between bytes of a partially received frame.
  always_comb begin
    idle_d  = '0;
    timeout = 1'b0;
    if (state_q == StLoad && !ldr.rx_rdy && byte_cnt_q != '0) begin
      if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        idle_d = idle_q + IdleW'(1);
      end
    end
    frame_err_d = timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      idle_q      <= idle_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ldr.frame_err = frame_err_q;
`else
  // The timeout length only matters when the feature is built in.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout               = 1'b0;
  assign ldr.frame_err         = 1'b0;
`endif

  assign waddr = {byte_cnt_q, bit_cnt_q};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    clr_rx_rdy = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      StLoad: begin
        if (ldr.rx_rdy) begin
          clr_rx_rdy = 1'b1;
          shift_d    = ldr.rx_data;
          bit_cnt_d  = 3'd0;
          state_d    = StUnpack;
        end else if (timeout) begin
          byte_cnt_d = '0;
        end
      end
      StUnpack: begin
        mem_we    = 1'b1;
        shift_d   = {1'b0, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_cnt_q == LastByte) begin
            state_d = StStart;
          end else begin
            byte_cnt_d = byte_cnt_q + 7'd1;
            state_d    = StLoad;
          end
        end
      end
      StStart: begin
        byte_cnt_d = '0;
        state_d    = StWaitCore;
      end
      StWaitCore: begin
        if (ldr.core_done) begin
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Addresses past the image read as zero rather than aliasing into the array.
  always_comb begin
    q_input_d = 1'b0;
    if (ldr.addr_input_unit < 10'(MemDepth)) begin
      q_input_d = mem_q[ldr.addr_input_unit];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      q_input_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      q_input_q  <= q_input_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[waddr] <= shift_q[0];
    end
  end

  assign ldr.clr_rx_rdy = clr_rx_rdy;
  assign ldr.start      = (state_q == StStart);
  assign ldr.busy       = (state_q == StStart) || (state_q == StWaitCore);
  assign ldr.q_input    = q_input_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// Self-checking bench for snn_input_loader: a frame-level model (byte queue -> image array,
// acceptance/start/busy timing rules) checked every cycle, plus directed literal checks.
module tb_snn_input_loader;
  localparam int unsigned TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_input_loader_if bus ();

  snn_input_loader #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ldr   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state
  bit         ref_mem [784];
  int         mcnt = 0;
  int         next_ok = 0;
  int         start_at = -1;
  int         fe_at = -1;
  int         idle = 0;
  bit         mbusy = 1'b0;
  bit         prev_busy = 1'b0;
  logic [9:0] prev_addr = '0;
  int         cyc = 0;

  // Observations of the DUT, used only for measured-timing checks
  int ack_count = 0;
  int start_count = 0;
  int fe_count = 0;
  int last_ack_cyc = 0;
  int last_start_cyc = 0;
  int last_done_cyc = 0;

  always @(negedge clk) begin : p_compare
    bit exp_clr, exp_start, exp_busy, exp_fe, exp_q;
    cyc++;
    if (!rst_n) begin
      chk("rst_clr_rx_rdy", 32'(bus.clr_rx_rdy), 0);
      chk("rst_start", 32'(bus.start), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_frame_err", 32'(bus.frame_err), 0);
      chk("rst_q_input", 32'(bus.q_input), 0);
      mcnt = 0; next_ok = 0; start_at = -1; fe_at = -1; idle = 0;
      mbusy = 1'b0; prev_busy = 1'b0;
    end else begin
      exp_clr   = bus.rx_rdy && !mbusy && start_at < 0 && cyc >= next_ok;
      exp_start = (cyc == start_at);
      exp_busy  = mbusy || exp_start;
      exp_fe    = (cyc == fe_at);
      chk("clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'(exp_clr));
      chk("start", 32'(bus.start), 32'(exp_start));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("frame_err", 32'(bus.frame_err), 32'(exp_fe));
      // Image is stable from the start cycle on, so reads are checkable then.
      if (prev_busy) begin
        exp_q = (prev_addr < 10'd784) ? ref_mem[prev_addr] : 1'b0;
        chk("q_input", 32'(bus.q_input), 32'(exp_q));
      end
      if (bus.clr_rx_rdy) begin ack_count++; last_ack_cyc = cyc; end
      if (bus.start) begin start_count++; last_start_cyc = cyc; end
      if (bus.frame_err) fe_count++;
      if (bus.core_done) last_done_cyc = cyc;

      if (exp_clr) begin
        for (int i = 0; i < 8; i++) ref_mem[mcnt * 8 + i] = bus.rx_data[i];
        mcnt++;
        next_ok = cyc + 9;
        idle = 0;
        if (mcnt == 98) begin
          start_at = cyc + 9;
          mcnt = 0;
        end
      end else if (!mbusy && start_at < 0 && cyc >= next_ok && mcnt > 0) begin
`ifdef SNN_INPUT_LOADER_TIMEOUT_EN
        idle++;
        if (idle == TO) begin
          fe_at = cyc + 1;
          mcnt = 0;
          idle = 0;
        end
`endif
      end
      if (exp_start) begin
        mbusy = 1'b1;
        start_at = -1;
      end else if (mbusy && bus.core_done) begin
        mbusy = 1'b0;
        next_ok = cyc + 1;
      end
      prev_busy = exp_busy;
      prev_addr = bus.addr_input_unit;
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.rx_rdy = 1'b0;
    bus.core_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    bus.rx_rdy = 1'b1;
    bus.rx_data = d;
    while (!got && n < 2000) begin
      @(negedge clk);
      if (bus.clr_rx_rdy) got = 1'b1;
      n++;
    end
    chk("ack_within_bound", 32'(got), 1);
    step();
    if (gap > 0) begin
      bus.rx_rdy = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic wait_start();
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (bus.start) got = 1'b1;
      n++;
    end
    chk("start_within_bound", 32'(got), 1);
    step();
  endtask

  task automatic core_done_pulse();
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
  endtask

  task automatic read_chk(input int a, input bit exp);
    bus.addr_input_unit = 10'(a);
    step();
    @(negedge clk);
    chk($sformatf("read_addr_%0d", a), 32'(bus.q_input), 32'(exp));
    step();
  endtask

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    int a0, s0, f0, prev_ack, n_new;
    bus.rx_rdy = 1'b0;
    bus.rx_data = '0;
    bus.addr_input_unit = '0;
    bus.core_done = 1'b0;
    step();
    do_reset();

    // Full frame of 0xA5 with idle gaps
    a0 = ack_count;
    s0 = start_count;
    for (int i = 0; i < 98; i++) send_byte(8'hA5, 20);
    chk("frame_ack_count", 32'(ack_count - a0), 98);
    chk("frame_start_count", 32'(start_count - s0), 1);
    chk("start_after_last_ack", 32'(last_start_cyc - last_ack_cyc), 9);
    @(negedge clk);
    chk("busy_after_frame", 32'(bus.busy), 1);
    step();
    read_chk(0, 1'b1);
    read_chk(1, 1'b0);
    read_chk(5, 1'b1);
    read_chk(783, 1'b1);
    core_done_pulse();
    @(negedge clk);
    chk("busy_drop_after_done", 32'(bus.busy), 0);
    step();

    // Back-pressure: rx_rdy held high throughout
    do_reset();
    s0 = start_count;
    prev_ack = 0;
    for (int i = 0; i < 98; i++) begin
      send_byte(8'(i), 0);
      if (i > 0) chk("ack_interval", 32'(last_ack_cyc - prev_ack), 9);
      prev_ack = last_ack_cyc;
    end
    repeat (30) step();
    chk("bp_start_count", 32'(start_count - s0), 1);
    chk("bp_no_ack_while_busy", 32'(last_ack_cyc), 32'(prev_ack));
    read_chk(24, 1'b1);  // byte 3 = 0x03, bit 0
    read_chk(26, 1'b0);  // byte 3 bit 2
    core_done_pulse();
    send_byte(8'h3C, 2);
    chk("ack_after_done", 32'(last_ack_cyc - last_done_cyc), 1);

    // Bit order: only the first and last image bits set
    do_reset();
    send_byte(8'h01, 2);
    for (int i = 1; i < 97; i++) send_byte(8'h00, 2);
    send_byte(8'h80, 0);
    bus.rx_rdy = 1'b0;
    wait_start();
    for (int a = 0; a < 784; a++) read_chk(a, (a == 0 || a == 783));
    core_done_pulse();

    // Reset mid-frame, then a full 0xFF frame
    do_reset();
    for (int i = 0; i < 50; i++) send_byte(8'h5A, 1);
    do_reset();
    s0 = start_count;
    for (int i = 0; i < 97; i++) send_byte(8'hFF, 1);
    chk("no_start_before_98", 32'(start_count - s0), 0);
    send_byte(8'hFF, 15);
    chk("post_reset_start_count", 32'(start_count - s0), 1);
    chk("post_reset_start_lat", 32'(last_start_cyc - last_ack_cyc), 9);
    for (int a = 0; a < 784; a++) read_chk(a, 1'b1);
    read_chk(900, 1'b0);
    read_chk(1023, 1'b0);
    core_done_pulse();

    // Inter-byte timeout
    do_reset();
    f0 = fe_count;
    for (int i = 0; i < 10; i++) send_byte(8'h33, 1);
    repeat (120) step();
`ifdef SNN_INPUT_LOADER_TIMEOUT_EN
    chk("timeout_frame_err", 32'(fe_count - f0), 1);
    n_new = 98;
`else
    chk("timeout_frame_err", 32'(fe_count - f0), 0);
    n_new = 88;
`endif
    s0 = start_count;
    for (int i = 0; i < n_new - 1; i++) send_byte(8'hC3, 1);
    chk("timeout_no_early_start", 32'(start_count - s0), 0);
    send_byte(8'hC3, 15);
    chk("timeout_start_count", 32'(start_count - s0), 1);
    read_chk(0, 1'b1);
    read_chk(2, 1'b0);
    core_done_pulse();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snn_input_loader.md
# snn_input_loader

Upstream feeder for the SNN inference core. Accepts 98 image bytes from the UART receiver and unpacks them LSB-first into an internal 784 x 1-bit input memory. Pulses `start` to the core once the frame is complete, then serves the core's synchronous `q_input` reads by address. Holds off further UART bytes until the core reports `done`.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: inter-byte idle limit in clocks. Used only when the timeout feature is compiled in.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `rx_rdy`  in  1  UART byte available; held high by the receiver until cleared
- `rx_data`  in  8  received byte, valid while `rx_rdy`
- `clr_rx_rdy`  out  1  one-cycle pulse acknowledging and consuming the current byte
- `addr_input_unit`  in  10  read address from the core, 0..783
- `q_input`  out  1  registered read data, `mem[addr_input_unit]` one cycle late
- `core_done`  in  1  core finished classification
- `start`  out  1  one-cycle pulse: frame loaded, core may begin
- `busy`  out  1  high from the `start` cycle until `core_done` is accepted
- `frame_err`  out  1  one-cycle pulse when a partial frame is discarded on timeout

## Operation
- Reset values: `clr_rx_rdy`=0, `start`=0, `busy`=0, `frame_err`=0, `q_input`=0, state=LOAD, byte_cnt=0, bit_cnt=0. Memory contents are not reset.
- Byte counter: byte_cnt, 7 bits, range 0..97. Bit counter: bit_cnt, 3 bits. Shift register: 8 bits.
- Write address = byte_cnt*8 + bit_cnt (10 bits). Byte k bit i lands at address 8k+i.
- State LOAD:
  - If `rx_rdy`=1: assert `clr_rx_rdy` combinationally, latch `rx_data` into the shift register, clear bit_cnt, go to UNPACK.
  - Otherwise stay in LOAD.
- State UNPACK, one bit per cycle for 8 cycles:
  - Write shift[0] to mem at the write address, shift right, increment bit_cnt.
  - On bit_cnt==7: if byte_cnt==97 go to START; otherwise increment byte_cnt and go to LOAD.
  - `rx_rdy` is not acknowledged in UNPACK; the byte waits.
- State START: `start`=1 and `busy`=1 for one cycle; clear byte_cnt; go to WAIT_CORE.
- State WAIT_CORE:
  - `busy`=1; `rx_rdy` is ignored and not acknowledged.
  - On `core_done`=1, go to LOAD; `busy` drops the following cycle.
- Read port is active every cycle in every state: `q_input` <= mem[`addr_input_unit`]. Addresses 784..1023 return 0.
- Write and read of the same address in the same cycle returns the old data. This never occurs in normal flow, because writes happen only outside WAIT_CORE.
- Unknown/illegal state encoding goes to LOAD.

## Timing
- Byte acceptance: `clr_rx_rdy` high in cycle C (state LOAD, `rx_rdy`=1). Bits are written in cycles C+1..C+8. Earliest next acceptance is C+9.
- Final byte accepted in C gives `start` in C+9.
- Read latency: exactly 1 cycle from `addr_input_unit` to `q_input`.
- `core_done` in cycle D makes the loader able to accept a byte in D+1.
- Reset asserted mid-frame or mid-classification: immediate return to reset values, partial frame abandoned, and the next byte is treated as byte 0.
- `core_done` outside WAIT_CORE is ignored.

## Configuration
- Macro: `SNN_INPUT_LOADER_TIMEOUT_EN`.
- Defined:
  - In LOAD with byte_cnt>0, an idle counter increments each cycle and clears on byte acceptance.
  - When it reaches `TIMEOUT_CYCLES`: pulse `frame_err` for one cycle, clear byte_cnt and the idle counter, and stay in LOAD.
  - The idle counter is held at 0 when byte_cnt==0, so no timeout occurs before the first byte.
- Undefined: no idle counter, and `frame_err` is tied to 0.

## Test plan
- Full frame: send 98 bytes of 0xA5 with `rx_rdy` gaps of 20 cycles.
  - Expect 98 `clr_rx_rdy` pulses and one `start` pulse 9 cycles after the last acknowledge.
  - Expect `busy`=1 afterward.
  - Reading address 0 gives 1, address 1 gives 0, address 5 gives 1, address 783 gives 1, each one cycle after the address is applied.
- Back-pressure: hold `rx_rdy`=1 continuously.
  - Expect acknowledges exactly every 9 cycles.
  - Expect no acknowledge while in WAIT_CORE, and the next acknowledge one cycle after `core_done`.
- Bit order: send byte 0 = 0x01 and byte 97 = 0x80, all others 0x00.
  - Expect mem[0]=1, mem[783]=1, and all other addresses 0.
- Reset mid-frame: send 50 bytes, pulse `rst_n` low, then send 98 bytes of 0xFF.
  - Expect exactly one `start` after the 98th post-reset byte, and all 784 addresses read 1.
- Timeout, macro defined with `TIMEOUT_CYCLES`=100: send 10 bytes, idle 100 cycles.
  - Expect one `frame_err` pulse.
  - A following 98-byte frame produces `start` after its 98th byte.
  - With the macro undefined, the same stimulus gives no `frame_err`, and `start` arrives after 88 of the new bytes.
- Out-of-range read: after a frame of 0xFF, drive address 900.
  - Expect `q_input`=0.
